// File: rtl/id_ex_register.sv
// ID/EX pipeline register: latches decode control and operands for the execute stage.
// Supports debug enable (freeze), hazard stall (hold) and hazard flush (bubble insertion).
`ifndef COMPLETE_WORD
`define COMPLETE_WORD 3'b011
`endif

module id_ex_register #(
  parameter int NB           = 32,
  parameter int NB_REGS      = 5,
  parameter int NB_OPCODE    = 6,
  parameter int NB_SIZE_TYPE = 3
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_enable,
  input  logic                    i_stall,
  input  logic                    i_flush,
  input  logic                    i_valid,
  input  logic                    i_ALUSrc,
  input  logic                    i_mem_read,
  input  logic                    i_mem_write,
  input  logic                    i_mem_to_reg,
  input  logic                    i_reg_write,
  input  logic                    i_branch,
  input  logic                    i_jump,
  input  logic                    i_signed,
  input  logic [1:0]              i_ExtensionMode,
  input  logic [NB_SIZE_TYPE-1:0] i_word_size,
  input  logic [NB_REGS-1:0]      i_reg_dir_to_write,
  input  logic [NB_REGS-1:0]      i_rs,
  input  logic [NB_REGS-1:0]      i_rt,
  input  logic [NB-1:0]           i_data_a,
  input  logic [NB-1:0]           i_data_b,
  input  logic [NB-1:0]           i_immediate,
  input  logic [NB-1:0]           i_pc4,
  input  logic [NB_OPCODE-1:0]    i_func_code,
  input  logic [NB_OPCODE-1:0]    i_opcode,
  output logic                    o_valid,
  output logic                    o_ALUSrc,
  output logic                    o_mem_read,
  output logic                    o_mem_write,
  output logic                    o_mem_to_reg,
  output logic                    o_reg_write,
  output logic                    o_branch,
  output logic                    o_jump,
  output logic                    o_signed,
  output logic [1:0]              o_ExtensionMode,
  output logic [NB_SIZE_TYPE-1:0] o_word_size,
  output logic [NB_REGS-1:0]      o_reg_dir_to_write,
  output logic [NB_REGS-1:0]      o_rs,
  output logic [NB_REGS-1:0]      o_rt,
  output logic [NB-1:0]           o_data_a,
  output logic [NB-1:0]           o_data_b,
  output logic [NB-1:0]           o_immediate,
  output logic [NB-1:0]           o_pc4,
  output logic [NB_OPCODE-1:0]    o_func_code,
  output logic [NB_OPCODE-1:0]    o_opcode,
  output logic                    o_bubble
);

  typedef struct packed {
    logic                    valid;
    logic                    alu_src;
    logic                    mem_read;
    logic                    mem_write;
    logic                    mem_to_reg;
    logic                    reg_write;
    logic                    branch;
    logic                    jump;
    logic                    is_signed;
    logic [1:0]              ext_mode;
    logic [NB_SIZE_TYPE-1:0] word_size;
    logic [NB_REGS-1:0]      reg_dir_to_write;
    logic [NB_REGS-1:0]      rs;
    logic [NB_REGS-1:0]      rt;
    logic [NB-1:0]           data_a;
    logic [NB-1:0]           data_b;
    logic [NB-1:0]           immediate;
    logic [NB-1:0]           pc4;
    logic [NB_OPCODE-1:0]    func_code;
    logic [NB_OPCODE-1:0]    opcode;
  } stage_t;

  typedef enum logic [1:0] {
    ACT_HOLD   = 2'b00,
    ACT_BUBBLE = 2'b01,
    ACT_LOAD   = 2'b10
  } action_t;

  // Bubble contents: all side-effect controls cleared, size left at a full word.
  function automatic stage_t bubble_value();
    stage_t b;
    b           = '0;
    b.word_size = `COMPLETE_WORD;
    return b;
  endfunction

  stage_t  stage_r;
  stage_t  stage_next_s;
  stage_t  in_s;
  logic    bubble_r;
  logic    bubble_next_s;
  action_t action_s;

  assign in_s = '{
    valid:            i_valid,
    alu_src:          i_ALUSrc,
    mem_read:         i_mem_read,
    mem_write:        i_mem_write,
    mem_to_reg:       i_mem_to_reg,
    reg_write:        i_reg_write,
    branch:           i_branch,
    jump:             i_jump,
    is_signed:        i_signed,
    ext_mode:         i_ExtensionMode,
    word_size:        i_word_size,
    reg_dir_to_write: i_reg_dir_to_write,
    rs:               i_rs,
    rt:               i_rt,
    data_a:           i_data_a,
    data_b:           i_data_b,
    immediate:        i_immediate,
    pc4:              i_pc4,
    func_code:        i_func_code,
    opcode:           i_opcode
  };

  // Priority decode: freeze over flush over stall over load.
  always_comb begin
    action_s = ACT_HOLD;
    if (!i_enable) begin
      action_s = ACT_HOLD;
    end else if (i_flush) begin
      action_s = ACT_BUBBLE;
    end else if (i_stall) begin
      action_s = ACT_HOLD;
    end else begin
      action_s = ACT_LOAD;
    end
  end

  // Next-state selection for contents and bubble flag.
  always_comb begin
    stage_next_s  = stage_r;
    bubble_next_s = bubble_r;
    case (action_s)
      ACT_BUBBLE: begin
        stage_next_s  = bubble_value();
        bubble_next_s = 1'b1;
      end
      ACT_LOAD: begin
        stage_next_s  = in_s;
        bubble_next_s = 1'b0;
      end
      ACT_HOLD: begin
        stage_next_s  = stage_r;
        bubble_next_s = bubble_r;
      end
      default: begin
        stage_next_s  = bubble_value();
        bubble_next_s = 1'b1;
      end
    endcase
  end

  // Pipeline state; reset loads a bubble immediately.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      stage_r  <= bubble_value();
      bubble_r <= 1'b1;
    end else begin
      stage_r  <= stage_next_s;
      bubble_r <= bubble_next_s;
    end
  end

  assign o_valid            = stage_r.valid;
  assign o_ALUSrc           = stage_r.alu_src;
  assign o_mem_read         = stage_r.mem_read;
  assign o_mem_write        = stage_r.mem_write;
  assign o_mem_to_reg       = stage_r.mem_to_reg;
  assign o_reg_write        = stage_r.reg_write;
  assign o_branch           = stage_r.branch;
  assign o_jump             = stage_r.jump;
  assign o_signed           = stage_r.is_signed;
  assign o_ExtensionMode    = stage_r.ext_mode;
  assign o_word_size        = stage_r.word_size;
  assign o_reg_dir_to_write = stage_r.reg_dir_to_write;
  assign o_rs               = stage_r.rs;
  assign o_rt               = stage_r.rt;
  assign o_data_a           = stage_r.data_a;
  assign o_data_b           = stage_r.data_b;
  assign o_immediate        = stage_r.immediate;
  assign o_pc4              = stage_r.pc4;
  assign o_func_code        = stage_r.func_code;
  assign o_opcode           = stage_r.opcode;
  assign o_bubble           = bubble_r;

endmodule
